// File: rtl/l2_ctrl_pkg.sv
// Shared types and select encodings for the L2 cache controller.
package l2_ctrl_pkg;

  // Controller states, in the order a miss walks through them.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TAG     = 3'd1,
    WB      = 3'd2,
    FILL    = 3'd3,
    REFETCH = 3'd4
  } state_e;

  // data_sel: source of the line written into the data array.
  localparam logic DSEL_CPU = 1'b0;  // merge of the upstream write
  localparam logic DSEL_MEM = 1'b1;  // line returned by the adapter

  // addr_sel: which address the datapath drives onto pmem_address.
  localparam logic ASEL_REQ    = 1'b0;  // current request address
  localparam logic ASEL_VICTIM = 1'b1;  // victim tag + request set

endpackage

// File: rtl/l2_cache_control_sat_counter.sv
// Saturating up-counter used for the L2 performance statistics.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count up on inc, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/l2_cache_control.sv
// L2 cache controller: tag compare, dirty-victim writeback, line fill and
// re-lookup, plus hit/miss/writeback performance counters.
//
// Handshakes: mem_read/mem_write are held by the requester until the single
// cycle mem_resp pulse; pmem_read/pmem_write are held by this block until the
// adapter's pmem_resp, and the two are never high together. A request or
// command is taken as complete only in the cycle its response is high.
module l2_cache_control
  import l2_ctrl_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int CNT_W = 32,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic             hit,
  input  logic [WAY_W-1:0] hit_way,
  input  logic [WAY_W-1:0] victim_way,
  input  logic             victim_dirty,
  output logic [WAY_W-1:0] way_sel,
  output logic             load_data,
  output logic             data_sel,
  output logic             load_tag,
  output logic             set_valid,
  output logic             set_dirty,
  output logic             clr_dirty,
  output logic             update_lru,
  output logic             addr_sel,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);

  state_e           state_q, state_d;
  logic [WAY_W-1:0] vway_q;
  logic             missed_q;
  logic             req;
  logic             hit_inc, miss_inc, wb_inc;

  assign req = mem_read | mem_write;

  // State, latched victim way and the "this request already missed" flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      vway_q   <= '0;
      missed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        missed_q <= 1'b0;
      end else if (miss_inc) begin
        missed_q <= 1'b1;
        vway_q   <= victim_way;
      end
    end
  end

  // Next state and all control outputs; everything is forced low during rst
  // so a reset landing on an adapter response cannot write the arrays.
  always_comb begin
    state_d    = state_q;
    mem_resp   = 1'b0;
    way_sel    = '0;
    load_data  = 1'b0;
    data_sel   = DSEL_CPU;
    load_tag   = 1'b0;
    set_valid  = 1'b0;
    set_dirty  = 1'b0;
    clr_dirty  = 1'b0;
    update_lru = 1'b0;
    addr_sel   = ASEL_REQ;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    wb_inc     = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (req) state_d = TAG;
        end
        TAG: begin
          if (!req) begin
            state_d = IDLE;
          end else if (hit) begin
            mem_resp   = 1'b1;
            update_lru = 1'b1;
            way_sel    = hit_way;
            hit_inc    = !missed_q;
            // A simultaneous read and write is serviced as a write.
            if (mem_write) begin
              load_data = 1'b1;
              data_sel  = DSEL_CPU;
              set_dirty = 1'b1;
            end
            state_d = IDLE;
          end else begin
            miss_inc = 1'b1;
            state_d  = victim_dirty ? WB : FILL;
          end
        end
        WB: begin
          pmem_write = 1'b1;
          addr_sel   = ASEL_VICTIM;
          way_sel    = vway_q;
          if (pmem_resp) begin
            clr_dirty = 1'b1;
            wb_inc    = 1'b1;
            state_d   = FILL;
          end
        end
        FILL: begin
          pmem_read = 1'b1;
          addr_sel  = ASEL_REQ;
          way_sel   = vway_q;
          if (pmem_resp) begin
            load_data = 1'b1;
            data_sel  = DSEL_MEM;
            load_tag  = 1'b1;
            set_valid = 1'b1;
            clr_dirty = 1'b1;
            state_d   = REFETCH;
          end
        end
        REFETCH: begin
          // Arrays are sync-read: give them a cycle to present the new line.
          state_d = TAG;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (hit_inc),
    .count(hit_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (miss_inc),
    .count(miss_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wb_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (wb_inc),
    .count(wb_count)
  );

endmodule

// File: doc/l2_cache_control.md
Name: l2_cache_control

Overview:
- FSM controller for the L2 cache between the I/D cache arbiter and the cacheline adapter.
- Sequences the L2 datapath (tag/data/valid/dirty/LRU arrays, owned elsewhere): tag compare, dirty-victim writeback, line fill, re-lookup.
- Drives the adapter read/write handshake.
- Keeps saturating hit/miss/writeback performance counters.

Parameters:
- WAYS, 4, associativity; WAY_W = $clog2(WAYS).
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- mem_read  in  1  upstream (arbiter) read request; held until mem_resp
- mem_write  in  1  upstream write request; held until mem_resp
- mem_resp  out  1  one-cycle completion pulse to upstream
- hit  in  1  datapath: some valid way's tag matches request address
- hit_way  in  WAY_W  matching way when hit=1
- victim_way  in  WAY_W  LRU-selected replacement way
- victim_dirty  in  1  dirty bit of victim_way at request set
- way_sel  out  WAY_W  way targeted by array writes / writeback read
- load_data  out  1  write data array line in way_sel
- data_sel  out  1  0 = upstream write merge (DSEL_CPU), 1 = pmem line (DSEL_MEM)
- load_tag  out  1  write request tag into way_sel
- set_valid  out  1  set valid bit of way_sel
- set_dirty  out  1  set dirty bit of way_sel
- clr_dirty  out  1  clear dirty bit of way_sel
- update_lru  out  1  mark way_sel most-recently-used
- addr_sel  out  1  0 = request address (ASEL_REQ), 1 = victim tag + set (ASEL_VICTIM) onto pmem_address
- pmem_read  out  1  adapter line read; held until pmem_resp
- pmem_write  out  1  adapter line write; held until pmem_resp
- pmem_resp  in  1  adapter done
- hit_count  out  CNT_W  first-look hits
- miss_count  out  CNT_W  misses
- wb_count  out  CNT_W  completed writebacks

Behaviour:
- Reset: synchronous, active-high. State IDLE, all 1-bit outputs 0, way_sel 0, counters 0, internal regs 0.
- Reset mid-transaction: next cycle IDLE with pmem_read/pmem_write low. No array writes are issued. The adapter shares rst.
- Outputs are combinational from state and inputs (Moore + Mealy). Undriven defaults are 0.
- States:
  - IDLE: mem_read|mem_write -> TAG. Arrays are sync-read, so status is valid in TAG. Clear missed flag.
  - TAG, no request (requester dropped, illegal): -> IDLE, no side effects.
  - TAG, hit:
    - mem_resp=1, update_lru=1, way_sel=hit_way.
    - If mem_write: load_data=1, data_sel=0, set_dirty=1.
    - mem_read&mem_write together are treated as a write.
    - hit_count++ only if missed flag=0.
    - -> IDLE.
  - TAG, miss:
    - Latch victim_way into vway_q; set missed flag; miss_count++.
    - victim_dirty -> WB, else -> FILL.
  - WB:
    - pmem_write=1, addr_sel=1, way_sel=vway_q.
    - On pmem_resp: clr_dirty=1, wb_count++, -> FILL.
  - FILL:
    - pmem_read=1, addr_sel=0, way_sel=vway_q.
    - On pmem_resp: load_data=1, data_sel=1, load_tag=1, set_valid=1, clr_dirty=1, -> REFETCH.
  - REFETCH: no outputs; lets arrays settle for re-read. -> TAG.
- vway_q is held from miss through FILL. way_sel in WB/FILL ignores later victim_way changes.
- Latency:
  - Hit: mem_resp in the cycle after the request is first seen in IDLE.
  - Clean miss: 1 + fill cycles + 2.
  - Dirty miss: additionally + writeback cycles.
- A second TAG after a fill must hit. If the datapath reports miss again, the controller repeats the miss path and counts again (no special case).
- pmem_read and pmem_write are never high together.
- Counters saturate at all-ones; no wrap.

Decomposition:
- Package l2_ctrl_pkg:
  - state enum: IDLE, TAG, WB, FILL, REFETCH.
  - data_sel constants DSEL_CPU / DSEL_MEM.
  - addr_sel constants ASEL_REQ / ASEL_VICTIM.
- Sub-module sat_counter (CNT_W param; inputs inc, rst), instantiated three times.

Test Plan:
- Reset: assert rst 2 cycles mid-activity -> all outputs 0, counters 0, pmem_read/pmem_write low next cycle.
- Write hit: mem_write=1, hit=1, hit_way=3 -> cycle after request:
  - mem_resp=1, load_data=1, data_sel=0, set_dirty=1, update_lru=1, way_sel=3.
  - hit_count=1.
- Clean read miss: hit=0, victim_dirty=0, victim_way=1, pmem_resp after 4 cycles:
  - pmem_read high 4 cycles.
  - Then load_data/load_tag/set_valid/clr_dirty with way_sel=1, data_sel=1.
  - REFETCH, then TAG with hit=1 -> mem_resp.
  - miss_count=1, hit_count=0.
- Dirty miss: victim_dirty=1, victim_way=2, victim_way changed to 0 during WB:
  - pmem_write with addr_sel=1, way_sel=2 throughout.
  - clr_dirty on resp, then FILL on way 2.
  - wb_count=1; pmem_read/pmem_write never overlap.
- Reset mid-FILL: rst while pmem_read=1 -> next cycle IDLE, pmem_read=0, no load_data pulse, counters 0.
- Saturation: CNT_W=4, 17 back-to-back read hits -> hit_count=15.
